// File: rtl/s2_conv_pkg.sv
// Shared types, default sizing and the output requantisation rule for the
// stage-2 convolution window engine.
package s2_conv_pkg;

  localparam int DATA_W_DEF = 17;
  localparam int FRAC_DEF   = 8;
  localparam int IMG_H_DEF  = 8;
  localparam int IMG_W_DEF  = 8;
  localparam int IN_CH_DEF  = 3;
  localparam int K_DEF      = 3;
  localparam int ACC_W_DEF  = 40;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // acc carries 2*frac fractional bits; result is ReLU'd, truncated back to
  // frac fractional bits and clipped to the largest positive data_w word.
  function automatic logic [63:0] sat_relu(input logic signed [63:0] acc,
                                           input logic signed [63:0] bias,
                                           input int data_w,
                                           input int frac);
    logic signed [63:0] sum;
    logic signed [63:0] q;
    logic signed [63:0] max_v;
    sum   = acc + (bias <<< frac);
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    if (sum < 64'sd0) begin
      q = 64'sd0;
    end else begin
      q = sum >>> frac;
      if (q > max_v) q = max_v;
    end
    return q;
  endfunction

endpackage

// File: rtl/s2_conv_window_engine_if.sv
// Result stream of the convolution engine.
// A result transfers on a clock edge where out_valid && out_ready; while
// out_valid is high and out_ready low, out_data/out_row/out_col/out_last hold.
interface s2_conv_window_engine_if #(
  parameter int DATA_W = 17,
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/mult.sv
// Full-precision signed multiplier, combinational.
module mult #(
  parameter int IWIDTH = 17,
  parameter int OWIDTH = 34
) (
  input  logic signed [IWIDTH-1:0] a_i,
  input  logic signed [IWIDTH-1:0] b_i,
  output logic signed [OWIDTH-1:0] p_o
);
  assign p_o = OWIDTH'(a_i) * OWIDTH'(b_i);
endmodule

// File: rtl/s2_mac_tree.sv
// K*K product registers (first stage) feeding a registered sum of all taps
// (second stage); both stages advance only when en_i is high.
module s2_mac_tree #(
  parameter int DATA_W = 17,
  parameter int K      = 3,
  localparam int TAPS  = K * K,
  localparam int SUM_W = 2 * DATA_W + ((TAPS > 1) ? $clog2(TAPS) : 0)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] win_i [TAPS],
  input  logic signed [DATA_W-1:0] wgt_i [TAPS],
  output logic signed [SUM_W-1:0]  sum_o
);

  logic signed [2*DATA_W-1:0] prod   [TAPS];
  logic signed [2*DATA_W-1:0] prod_q [TAPS];
  logic signed [SUM_W-1:0]    sum_d;
  logic signed [SUM_W-1:0]    sum_q;

  for (genvar t = 0; t < TAPS; t++) begin : g_mult
    mult #(
      .IWIDTH(DATA_W),
      .OWIDTH(2 * DATA_W)
    ) u_mult (
      .a_i(win_i[t]),
      .b_i(wgt_i[t]),
      .p_o(prod[t])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) prod_q[t] <= '0;
    end else if (en_i) begin
      prod_q <= prod;
    end
  end

  // Headroom of clog2(TAPS) bits keeps the tap sum exact.
  always_comb begin
    sum_d = '0;
    for (int t = 0; t < TAPS; t++) sum_d = sum_d + SUM_W'(prod_q[t]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else if (en_i) sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/s2_conv_window_engine.sv
// Self-sequencing stride-1 convolution: one input channel per cycle through a
// four-stage pipeline (products, tap sum, channel accumulate, requantise).
module s2_conv_window_engine
  import s2_conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IN_CH  = IN_CH_DEF,
  parameter int K      = K_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic signed [DATA_W-1:0] input_tensor_i [IMG_H][IMG_W][IN_CH],
  input  logic signed [DATA_W-1:0] filter_i [K][K][IN_CH],
  input  logic signed [DATA_W-1:0] bias_i,
  output logic                     busy_o,
  output logic                     done_o,
  output state_t                   state_o,
  s2_conv_window_engine_if.master  out_if
);

  localparam int OH    = IMG_H - K + 1;
  localparam int OW    = IMG_W - K + 1;
  localparam int ROW_W = (OH > 1) ? $clog2(OH) : 1;
  localparam int COL_W = (OW > 1) ? $clog2(OW) : 1;
  localparam int CH_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int RI_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CI_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int TAPS  = K * K;
  localparam int SUM_W = 2 * DATA_W + ((TAPS > 1) ? $clog2(TAPS) : 0);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             en, issue, last_ch, last_col, last_row;

  logic              s1_vld_q, s1_first_q, s1_last_q;
  logic [ROW_W-1:0]  s1_row_q;
  logic [COL_W-1:0]  s1_col_q;
  logic              s2_vld_q, s2_first_q, s2_last_q;
  logic [ROW_W-1:0]  s2_row_q;
  logic [COL_W-1:0]  s2_col_q;
  logic              acc_vld_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum_ext;
  logic [ROW_W-1:0]  acc_row_q;
  logic [COL_W-1:0]  acc_col_q;
  logic              out_vld_q, out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ROW_W-1:0]  out_row_q;
  logic [COL_W-1:0]  out_col_q;

  logic signed [DATA_W-1:0] win [TAPS];
  logic signed [DATA_W-1:0] wgt [TAPS];
  logic signed [SUM_W-1:0]  tree_sum;

  // A full output register with no taker freezes the whole engine.
  assign en       = !out_vld_q || out_if.out_ready;
  assign issue    = (state_q == S_RUN);
  assign last_ch  = (ch_q == CH_W'(IN_CH - 1));
  assign last_col = (col_q == COL_W'(OW - 1));
  assign last_row = (row_q == ROW_W'(OH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
    end else if (en) begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
          ch_d    = '0;
        end
      end
      S_RUN: begin
        ch_d = ch_q + CH_W'(1);
        if (last_ch) begin
          ch_d  = '0;
          col_d = col_q + COL_W'(1);
          if (last_col) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
            if (last_row) begin
              row_d   = '0;
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (out_vld_q && out_if.out_ready && out_last_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o  = (state_q == S_DONE);
  assign state_o = state_q;

  for (genvar ky = 0; ky < K; ky++) begin : g_ky
    for (genvar kx = 0; kx < K; kx++) begin : g_kx
      logic [RI_W-1:0] ri;
      logic [CI_W-1:0] ci;
      assign ri = RI_W'(row_q) + RI_W'(ky);
      assign ci = CI_W'(col_q) + CI_W'(kx);
      assign win[ky*K+kx] = input_tensor_i[ri][ci][ch_q];
      assign wgt[ky*K+kx] = filter_i[ky][kx][ch_q];
    end
  end

  s2_mac_tree #(
    .DATA_W(DATA_W),
    .K     (K)
  ) u_mac_tree (
    .clk  (clk),
    .rst  (rst),
    .en_i (en),
    .win_i(win),
    .wgt_i(wgt),
    .sum_o(tree_sum)
  );

  // Position/channel tags travel beside the mac tree's two register stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_row_q   <= '0;
      s2_col_q   <= '0;
    end else if (en) begin
      s1_vld_q   <= issue;
      s1_first_q <= (ch_q == '0);
      s1_last_q  <= last_ch;
      s1_row_q   <= row_q;
      s1_col_q   <= col_q;
      s2_vld_q   <= s1_vld_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_row_q   <= s1_row_q;
      s2_col_q   <= s1_col_q;
    end
  end

  assign sum_ext = ACC_W'(tree_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_vld_q <= 1'b0;
      acc_q     <= '0;
      acc_row_q <= '0;
      acc_col_q <= '0;
    end else if (en) begin
      acc_vld_q <= s2_vld_q && s2_last_q;
      if (s2_vld_q) begin
        acc_q     <= s2_first_q ? sum_ext : acc_q + sum_ext;
        acc_row_q <= s2_row_q;
        acc_col_q <= s2_col_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      out_last_q <= 1'b0;
    end else if (en) begin
      out_vld_q <= acc_vld_q;
      if (acc_vld_q) begin
        out_data_q <= DATA_W'(sat_relu(64'(acc_q), 64'(bias_i), DATA_W, FRAC));
        out_row_q  <= acc_row_q;
        out_col_q  <= acc_col_q;
        out_last_q <= (acc_row_q == ROW_W'(OH - 1)) && (acc_col_q == COL_W'(OW - 1));
      end
    end
  end

  assign out_if.out_valid = out_vld_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_row   = out_row_q;
  assign out_if.out_col   = out_col_q;
  assign out_if.out_last  = out_last_q;

endmodule
